// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, default widths
// and the fixed requester slot assignment.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ  = 3;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam int REQ_FETCH = 0;
  localparam int REQ_CORE  = 1;
  localparam int REQ_HOST  = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first set request searched upward from ptr_i, wrapping modulo N_REQ.
// Purely combinational, no state.
module mem_port_arbiter_rr_pick #(
  parameter  int N_REQ = 3,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o
);

  logic             found;
  logic [IDX_W-1:0] cand;
  int               pos;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    pos       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      cand = IDX_W'(pos);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        win_idx_o      = cand;
        win_oh_o[cand] = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port synchronous memory; grant is combinational in IDLE,
// writes take 2 cycles, reads 2+MEM_LAT cycles; requesters wait (hold req) until granted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         we_i,
  input  logic [N_REQ-1:0]         lock_i,
  input  logic [N_REQ*ADDR_W-1:0]  addr_i,
  input  logic [N_REQ*DATA_W-1:0]  wdata_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     busy_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic                     mem_wren_o,
  input  logic [DATA_W-1:0]        mem_rdata_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lock_hold_q, lock_hold_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [N_REQ-1:0]  rr_oh, win_oh, gnt;
  logic [IDX_W-1:0]  rr_idx, win_idx;
  logic              rr_any, locked_win;

  mem_port_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_oh_o  (rr_oh),
    .win_idx_o (rr_idx),
    .any_o     (rr_any)
  );

  // A held lock only wins while its owner keeps requesting; otherwise plain round-robin.
  assign locked_win = lock_hold_q && req_i[owner_q];
  assign win_idx    = locked_win ? owner_q : rr_idx;
  assign win_oh     = locked_win ? (N_REQ'(1) << owner_q) : rr_oh;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    lock_hold_d = lock_hold_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    gnt         = '0;
    case (state_q)
      IDLE: begin
        if (lock_hold_q && !req_i[owner_q]) lock_hold_d = 1'b0;
        if (rr_any) begin
          gnt         = win_oh;
          owner_d     = win_idx;
          ptr_d       = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
          mem_addr_d  = addr_i[win_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata_i[win_idx*DATA_W +: DATA_W];
          mem_wren_d  = we_i[win_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_wren_q) begin
          lock_hold_d = lock_i[owner_q];
          state_d     = IDLE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d     = mem_rdata_i;
          rvalid_d    = N_REQ'(1) << owner_q;
          lock_hold_d = lock_i[owner_q];
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      lock_hold_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      lock_hold_q <= lock_hold_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Grant is combinational from req, so mask it while reset is asserted.
  assign gnt_o       = reset ? '0 : gnt;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state_q != IDLE);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wren_o  = mem_wren_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scoreboarded MEM_LAT=1 instance plus a MEM_LAT=3 instance.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LAT_A = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [N-1:0]    req, we, lock, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            busy, mem_wren;

  logic [N-1:0]    b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [N*AW-1:0] b_addr;
  logic [N*DW-1:0] b_wdata;
  logic [DW-1:0]   b_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0]   b_mem_addr;
  logic            b_busy, b_mem_wren;

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .lock_i(lock), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wren_o(mem_wren),
    .mem_rdata_i(mem_rdata));

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .req_i(b_req), .we_i(b_we), .lock_i(b_lock), .addr_i(b_addr),
    .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .busy_o(b_busy),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_wren_o(b_mem_wren),
    .mem_rdata_i(b_mem_rdata));

  // Behavioural memories: A has 1-cycle read latency, B a 3-stage read pipeline.
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] mem_a_rd;
  always @(posedge clk) begin
    if (mem_wren) mem_a[mem_addr[7:0]] <= mem_wdata;
    mem_a_rd <= mem_a[mem_addr[7:0]];
  end
  assign mem_rdata = mem_a_rd;

  logic [DW-1:0] mem_b [0:255];
  logic [DW-1:0] b_pipe [0:2];
  always @(posedge clk) begin
    if (b_mem_wren) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    b_pipe[0] <= mem_b[b_mem_addr[7:0]];
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int idx; logic [DW-1:0] data; int cyc; } rd_exp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic we; } iss_exp_t;
  rd_exp_t  rd_q[$];
  iss_exp_t iss_q[$];
  int       gnt_log[$];
  int       gcyc_log[$];
  rd_exp_t  e;
  int       w;

  // Monitor for instance A: checks issue cycle, read returns, and logs grants.
  always @(negedge clk) begin
    if (!reset) begin
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        chk("mem_addr", mem_addr, iss_q[0].addr);
        chk("mem_wren", mem_wren, iss_q[0].we);
        if (iss_q[0].we) chk("mem_wdata", mem_wdata, iss_q[0].wdata);
        void'(iss_q.pop_front());
      end else if (mem_wren) begin
        chk("mem_wren_idle", mem_wren, 0);
      end
      if (rvalid != '0) begin
        if (rd_q.size() == 0) chk("rvalid_unexp", rvalid, 0);
        else begin
          e = rd_q.pop_front();
          chk("rvalid_idx", rvalid, 32'(1) << e.idx);
          chk("rdata", rdata, e.data);
          chk("rvalid_cyc", cyc, e.cyc);
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        chk("rvalid_missing", 0, 1);
        void'(rd_q.pop_front());
      end
      if (gnt != '0) begin
        chk("gnt_onehot", $countones(gnt), 1);
        w = 0;
        for (int k = 0; k < N; k++) if (gnt[k]) w = k;
        gnt_log.push_back(w);
        gcyc_log.push_back(cyc);
        iss_q.push_back('{cyc + 1, addr[w*AW +: AW], wdata[w*DW +: DW], we[w]});
        if (we[w]) ref_mem[addr[w*AW +: 8]] = wdata[w*DW +: DW];
        else rd_q.push_back('{w, ref_mem[addr[w*AW +: 8]], cyc + 2 + LAT_A});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[k] = 1'b1;
    we[k]  = wr;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic wait_gnt(input int k, input string tag, output int gc);
    gc = -1;
    for (int t = 0; t < 50 && gc < 0; t++) begin
      @(negedge clk);
      if (gnt[k]) gc = cyc;
    end
    if (gc < 0) chk({tag, "_timeout"}, 0, 1);
    tick(1);
  endtask

  task automatic drain();
    int t = 0;
    while ((rd_q.size() > 0 || iss_q.size() > 0 || busy) && t < 40) begin
      tick(1);
      t++;
    end
    chk("drain", (rd_q.size() > 0 || iss_q.size() > 0 || busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, t0, gb, g1, rv;
    for (int i = 0; i < 256; i++) begin
      mem_a[i]   = 16'hA000 + 16'(i);
      ref_mem[i] = 16'hA000 + 16'(i);
      mem_b[i]   = 16'h5A00 + 16'(i);
    end
    mem_a[16] = 16'hBEEF; ref_mem[16] = 16'hBEEF;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    b_req = '0; b_we = '0; b_lock = '0; b_addr = '0; b_wdata = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_rdata", rdata, 0);
    tick(1);

    // Single read of 0xBEEF at 0x0010 by fetch
    t0 = cyc;
    set_req(REQ_FETCH, 1'b0, 16'h0010, 16'h0);
    wait_gnt(REQ_FETCH, "rd_gnt", g);
    req[REQ_FETCH] = 1'b0;
    chk("rd_gnt_cyc", g, t0);
    drain();

    // Single write then readback by core
    set_req(REQ_CORE, 1'b1, 16'h0020, 16'h1234);
    wait_gnt(REQ_CORE, "wr_gnt", g);
    req[REQ_CORE] = 1'b0;
    drain();
    chk("wr_mem_content", mem_a[8'h20], 16'h1234);
    set_req(REQ_CORE, 1'b0, 16'h0020, 16'h0);
    wait_gnt(REQ_CORE, "rb_gnt", g);
    req[REQ_CORE] = 1'b0;
    drain();

    // Fairness from reset with all three reads held
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    gnt_log.delete(); gcyc_log.delete();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k + 1), '0);
    for (int t = 0; t < 40 && gnt_log.size() < 6; t++) tick(1);
    req = '0;
    chk("fair_count", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
      chk("fair_order", gnt_log[i], i % N);
      if (i > 0) chk("fair_spacing", gcyc_log[i] - gcyc_log[i-1], 3);
    end
    drain();

    // Lock: host holds the port for three accesses while fetch waits
    gnt_log.delete(); gcyc_log.delete();
    set_req(REQ_HOST, 1'b0, 16'h0005, '0);
    lock[REQ_HOST] = 1'b1;
    set_req(REQ_FETCH, 1'b0, 16'h0006, '0);
    req[REQ_FETCH] = 1'b0;
    for (int t = 0; t < 60 && gnt_log.size() < 4; t++) begin
      tick(1);
      if (gnt_log.size() >= 1) req[REQ_FETCH] = 1'b1;
      if (gnt_log.size() >= 3) begin lock[REQ_HOST] = 1'b0; req[REQ_HOST] = 1'b0; end
      if (gnt_log.size() >= 4) req[REQ_FETCH] = 1'b0;
    end
    req = '0; lock = '0;
    chk("lock_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk("lock_order", gnt_log[i], (i < 3) ? REQ_HOST : REQ_FETCH);
    drain();

    // Reset mid-read: core read, reset asserted in WAIT
    set_req(REQ_CORE, 1'b0, 16'h0007, '0);
    wait_gnt(REQ_CORE, "rst_rd_gnt", g);
    req[REQ_CORE] = 1'b0;
    tick(1);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_mem_wren", mem_wren, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rdata", rdata, 0);
    rd_q.delete(); iss_q.delete();
    tick(2);
    reset = 1'b0;
    gnt_log.delete(); gcyc_log.delete();
    set_req(REQ_CORE, 1'b0, 16'h0008, '0);
    set_req(REQ_HOST, 1'b0, 16'h0009, '0);
    for (int t = 0; t < 20 && gnt_log.size() < 2; t++) begin
      tick(1);
      if (gnt_log.size() >= 1 && gnt_log[0] == REQ_CORE) req[REQ_CORE] = 1'b0;
      if (gnt_log.size() >= 2) req[REQ_HOST] = 1'b0;
    end
    req = '0;
    chk("post_rst_count", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("post_rst_first", gnt_log[0], REQ_CORE);
    drain();

    // Long latency instance: read by fetch, core raises req in cycle 1
    b_req[0] = 1'b1;
    b_addr[0 +: AW] = 16'h0009;
    gb = -1;
    for (int t = 0; t < 20 && gb < 0; t++) begin
      @(negedge clk);
      if (b_gnt[0]) gb = cyc;
    end
    chk("b_gnt0_seen", (gb >= 0), 1);
    tick(1);
    b_req[0] = 1'b0;
    b_req[1] = 1'b1;
    b_addr[AW +: AW] = 16'h000A;
    rv = -1; g1 = -1;
    for (int t = 0; t < 20 && (rv < 0 || g1 < 0); t++) begin
      @(negedge clk);
      if (b_rvalid[0] && rv < 0) begin rv = cyc; chk("b_rdata0", b_rdata, 16'h5A09); end
      if (b_gnt[1] && g1 < 0) g1 = cyc;
    end
    chk("b_rvalid0_cyc", rv, gb + 5);
    chk("b_gnt1_cyc", g1, gb + 5);
    tick(1);
    b_req[1] = 1'b0;
    rv = -1;
    for (int t = 0; t < 20 && rv < 0; t++) begin
      @(negedge clk);
      if (b_rvalid[1]) begin rv = cyc; chk("b_rdata1", b_rdata, 16'h5A0A); end
    end
    chk("b_rvalid1_cyc", rv, g1 + 5);

    tick(5);
    chk("sb_empty", rd_q.size() + iss_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one single-port synchronous memory among `N_REQ` requesters, such as instruction fetch, the multi-core data memory controller and the host loader. Each requester presents a request with address, write-enable and write data. The arbiter grants one requester at a time, drives the memory port for that access, and returns read data with a per-requester valid pulse. An optional per-requester lock holds the grant across back-to-back accesses for bursts.

## Interface
- `N_REQ`, 3, number of requesters (2..8)
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 1, memory read latency in cycles from the sampled address to valid `mem_rdata` (≥1)

- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `req`  in  N_REQ  access request; held by the requester until its `gnt`
- `we`  in  N_REQ  1 = write, 0 = read, per requester
- `lock`  in  N_REQ  keep the grant for this requester's next access
- `addr`  in  N_REQ×ADDR_W  per-requester address
- `wdata`  in  N_REQ×DATA_W  per-requester write data
- `gnt`  out  N_REQ  one-hot, one-cycle acceptance pulse (combinational)
- `rvalid`  out  N_REQ  one-hot, one-cycle read-data-valid pulse (registered)
- `rdata`  out  DATA_W  read data, shared; meaningful when any `rvalid` is high
- `busy`  out  1  high when the state is not IDLE
- `mem_addr`  out  ADDR_W  memory address (registered)
- `mem_wdata`  out  DATA_W  memory write data (registered)
- `mem_wren`  out  1  memory write enable (registered)
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- **States:**
  - IDLE: arbitrating.
  - ISSUE: memory port driven.
  - WAIT: read latency countdown.
- **IDLE:**
  - If any `req` is high, pick the winner `w`, assert `gnt[w]` in the same cycle, and latch `owner=w`.
  - At the clock edge, register `mem_addr=addr[w]`, `mem_wdata=wdata[w]`, `mem_wren=we[w]`, then go to ISSUE.
  - If no `req` is high, `gnt` stays 0 and the state stays IDLE.
- **Winner selection:**
  - If `lock_hold` is set and `req[owner]` is high, `w=owner`.
  - Otherwise, `w` is the first set `req` bit searched upward from `ptr`, wrapping modulo `N_REQ`.
- **Pointer update:** `ptr` is updated to `(w+1) mod N_REQ` on every grant, locked grants included.
- **ISSUE:**
  - For a write: next state IDLE; `mem_wren` is cleared at that edge.
  - For a read: next state WAIT, with `cnt=MEM_LAT-1` and `mem_wren=0`.
- **WAIT:**
  - If `cnt==0`: register `rdata=mem_rdata`, pulse `rvalid[owner]` in the following cycle, and go to IDLE.
  - Otherwise, decrement `cnt`.
- **lock_hold:** `lock[owner]` is sampled when the access completes, at the exit from ISSUE (write) or WAIT (read). If `lock[owner]` is set and `req[owner]` is low in IDLE, arbitration falls back to round-robin and `lock_hold` clears.
- **Idle memory outputs:** `mem_addr` and `mem_wdata` hold their last values; `mem_wren` is 0 outside the ISSUE cycle of a write.
- **Dropped requests:** a `req` dropped before its grant is never granted. No access is ever issued without a `gnt`.
- **Reset:** asynchronous and immediate, including mid-access.
  - State returns to IDLE; `ptr`, `owner`, `cnt` and `lock_hold` go to 0.
  - All outputs go to 0.
  - A read aborted by reset never produces `rvalid`.

## Timing
- Cycle 0 is the grant cycle.
- **Write:** `mem_wren` is high only in cycle 1; the next grant is possible in cycle 2. Throughput is 1 write per 2 cycles.
- **Read:** address presented in cycle 1; `rvalid` in cycle `2+MEM_LAT`. The next grant is possible in that same cycle, so throughput is 1 read per `2+MEM_LAT` cycles.
- `gnt` depends combinationally on `req`, `ptr`, `lock_hold` and state only, never on `addr` or `wdata`.
- `rvalid` and `gnt` may be high in the same cycle for different requesters, or for the same requester when locked.

## Structure
- **Shared package:**
  - state enum `{IDLE, ISSUE, WAIT}`
  - defaults for `ADDR_W`, `DATA_W`, `N_REQ`
  - requester index constants: fetch=0, core array=1, host=2
- **Sub-module:** `rr_pick`, combinational. Inputs are `req` and `ptr`; outputs are the one-hot winner and its index, plus an any-request flag.

## Test plan
- **Single read:** `MEM_LAT=1`, memory holds 0xBEEF at address 0x0010, `req[0]` read at address 0x0010.
  - `gnt[0]` in cycle 0.
  - `mem_addr=0x0010` and `mem_wren=0` in cycle 1.
  - `rvalid[0]` and `rdata=0xBEEF` in cycle 3.
- **Single write:** `req[1]` write, address 0x0020, data 0x1234.
  - `mem_wren` high in cycle 1 only, with `mem_addr=0x0020` and `mem_wdata=0x1234`.
  - Memory readback of 0x0020 returns 0x1234.
- **Fairness:** all three requests held continuously from reset with reads → grant order 0, 1, 2, 0, 1, 2, with grants spaced 3 cycles apart.
- **Lock:** `req[2]` with `lock[2]` high for three accesses while `req[0]` is pending.
  - Grants go 2, 2, 2.
  - After `lock[2]` drops, the next grant is 0.
- **Reset mid-read:** reset asserted in WAIT.
  - All outputs go to 0 immediately and no `rvalid` appears.
  - After release, `req[1]`+`req[2]` → grant 1 first, since `ptr` is 0.
- **Long latency:** `MEM_LAT=3` read → `rvalid` in cycle 5; a `req` from another requester raised in cycle 1 is granted in cycle 5.
